// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FWFT FIFO with RTS throttling and receive irq
// Optional idle-timeout irq is built when UART_RX_FIFO_TIMEOUT_IRQ_EN is defined.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2  = 2,
  parameter int RTS_LEVEL   = 3,
  parameter int IRQ_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_read,
  input  logic                  rd_en,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  uart_rts,
  output logic                  irq
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_LVL = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] RTS_LVL   = RTS_LEVEL[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] LVL_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level_q;
  logic [DEPTH_LOG2:0]   level_next;
  logic                  in_read_q;
  logic                  pop;

  // The receiver drops in_valid one cycle after a read, so a back-to-back read would double-capture.
  assign in_read   = rstn && in_valid && (level_q < DEPTH_LVL) && !in_read_q && !flush;
  assign pop       = rd_en && out_valid && !flush;
  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;
  assign level     = level_q;

  always_comb begin
    level_next = level_q;
    if (flush)
      level_next = '0;
    else if (in_read && !pop)
      level_next = level_q + LVL_ONE;
    else if (!in_read && pop)
      level_next = level_q - LVL_ONE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      in_read_q <= 1'b0;
      uart_rts  <= 1'b1;
    end else begin
      in_read_q <= in_read;
      level_q   <= level_next;
      uart_rts  <= (level_next >= RTS_LVL);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (in_read) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_read) mem[wr_ptr] <= in_data;
  end

`ifdef UART_RX_FIFO_TIMEOUT_IRQ_EN
  localparam int             CNT_W   = $clog2(IRQ_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IRQ_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] idle_cnt;

  // Counter only runs while bytes sit untouched; any traffic or emptiness restarts it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_cnt <= '0;
      irq      <= 1'b0;
    end else begin
      if (in_read || pop || flush || !out_valid)
        idle_cnt <= '0;
      else if (idle_cnt != CNT_MAX)
        idle_cnt <= idle_cnt + CNT_ONE;
      irq <= (level_q >= RTS_LVL) || (out_valid && (idle_cnt == CNT_MAX));
    end
  end
`else
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      irq <= 1'b0;
    else
      irq <= (level_next != '0);
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
// Directed vector table, reset corners, then random traffic against a queue model.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rstn;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_read;
  logic       rd_en;
  logic       flush;
  logic       out_valid;
  logic [7:0] out_data;
  logic [2:0] level;
  logic       uart_rts;
  logic       irq;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_rx_fifo #(.DEPTH_LOG2(2), .RTS_LEVEL(3), .IRQ_TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_read(in_read),
    .rd_en(rd_en), .flush(flush), .out_valid(out_valid), .out_data(out_data),
    .level(level), .uart_rts(uart_rts), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       rd;
    logic       fl;
    logic       ir;
    logic       ov;
    logic [7:0] od;
    logic [2:0] lvl;
    logic       rts;
    logic       irq;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic iv, input logic [7:0] d, input logic rd, input logic fl,
                              input logic ir, input logic ov, input logic [7:0] od,
                              input logic [2:0] lvl, input logic rts, input logic irq_e);
    vec_t v;
    v.iv = iv; v.d = d; v.rd = rd; v.fl = fl;
    v.ir = ir; v.ov = ov; v.od = od; v.lvl = lvl; v.rts = rts; v.irq = irq_e;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ir, input logic ov, input logic [7:0] od,
                         input logic [2:0] lvl, input logic rts, input logic irq_e);
    chk({tag, ".in_read"}, in_read, ir);
    chk({tag, ".out_valid"}, out_valid, ov);
    chk({tag, ".out_data"}, out_data, od);
    chk({tag, ".level"}, level, lvl);
    chk({tag, ".uart_rts"}, uart_rts, rts);
`ifndef UART_RX_FIFO_TIMEOUT_IRQ_EN
    chk({tag, ".irq"}, irq, irq_e);
`endif
  endtask

  logic [7:0] mq[$];
  logic       m_prev;
  logic       m_rts;
  logic       m_irq;
  logic       e_ir;
  logic [7:0] e_od;

  initial begin
    rstn = 1'b0; in_valid = 1'b1; in_data = 8'hEE; rd_en = 1'b0; flush = 1'b0;

    // reset holds everything, even with a byte offered
    @(negedge clk); #2;
    chk_all("reset", 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    in_valid = 1'b0;
    rstn = 1'b1;
    #1 chk("release.uart_rts_before_edge", uart_rts, 1'b1);
    @(negedge clk); #2;
    chk("release.uart_rts_after_edge", uart_rts, 1'b0);

    // single byte, then pop it
    add(1, 8'hA5, 0, 0,  1, 0, 8'h00, 0, 0, 0);
    add(0, 8'h00, 0, 0,  0, 1, 8'hA5, 1, 0, 1);
    add(0, 8'h00, 1, 0,  0, 1, 8'hA5, 1, 0, 1);
    // in_valid held across 01..05: reads every second cycle, fifth waits while full
    add(1, 8'h01, 0, 0,  1, 0, 8'h00, 0, 0, 0);
    add(1, 8'h02, 0, 0,  0, 1, 8'h01, 1, 0, 1);
    add(1, 8'h02, 0, 0,  1, 1, 8'h01, 1, 0, 1);
    add(1, 8'h03, 0, 0,  0, 1, 8'h01, 2, 0, 1);
    add(1, 8'h03, 0, 0,  1, 1, 8'h01, 2, 0, 1);
    add(1, 8'h04, 0, 0,  0, 1, 8'h01, 3, 1, 1);
    add(1, 8'h04, 0, 0,  1, 1, 8'h01, 3, 1, 1);
    add(1, 8'h05, 0, 0,  0, 1, 8'h01, 4, 1, 1);
    add(1, 8'h05, 0, 0,  0, 1, 8'h01, 4, 1, 1);
    add(1, 8'h05, 1, 0,  0, 1, 8'h01, 4, 1, 1);
    add(1, 8'h05, 0, 0,  1, 1, 8'h02, 3, 1, 1);
    add(0, 8'h00, 1, 0,  0, 1, 8'h02, 4, 1, 1);
    add(0, 8'h00, 1, 0,  0, 1, 8'h03, 3, 1, 1);
    add(0, 8'h00, 1, 0,  0, 1, 8'h04, 2, 0, 1);
    add(0, 8'h00, 1, 0,  0, 1, 8'h05, 1, 0, 1);
    add(0, 8'h00, 1, 0,  0, 0, 8'h00, 0, 0, 0);
    add(0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 0);
    // fill to 2, then ten push+pop cycles wrapping the pointers
    add(1, 8'h10, 0, 0,  1, 0, 8'h00, 0, 0, 0);
    add(0, 8'h00, 0, 0,  0, 1, 8'h10, 1, 0, 1);
    add(1, 8'h11, 0, 0,  1, 1, 8'h10, 1, 0, 1);
    add(0, 8'h00, 0, 0,  0, 1, 8'h10, 2, 0, 1);
    for (int k = 0; k < 10; k++) begin
      add(1, 8'(8'h12 + k), 1, 0,  1, 1, 8'(8'h10 + k), 2, 0, 1);
      add(0, 8'h00,          0, 0,  0, 1, 8'(8'h11 + k), 2, 0, 1);
    end
    add(0, 8'h00, 1, 0,  0, 1, 8'h1A, 2, 0, 1);
    add(0, 8'h00, 1, 0,  0, 1, 8'h1B, 1, 0, 1);
    add(0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 0);
    // fill to 3, flush together with in_valid
    add(1, 8'h20, 0, 0,  1, 0, 8'h00, 0, 0, 0);
    add(0, 8'h00, 0, 0,  0, 1, 8'h20, 1, 0, 1);
    add(1, 8'h21, 0, 0,  1, 1, 8'h20, 1, 0, 1);
    add(0, 8'h00, 0, 0,  0, 1, 8'h20, 2, 0, 1);
    add(1, 8'h22, 0, 0,  1, 1, 8'h20, 2, 0, 1);
    add(0, 8'h00, 0, 0,  0, 1, 8'h20, 3, 1, 1);
    add(1, 8'h33, 0, 1,  0, 1, 8'h20, 3, 1, 1);
    add(0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 0);
    add(1, 8'h44, 0, 0,  1, 0, 8'h00, 0, 0, 0);
    add(0, 8'h00, 0, 0,  0, 1, 8'h44, 1, 0, 1);

    foreach (tbl[i]) begin
      @(negedge clk);
      in_valid = tbl[i].iv; in_data = tbl[i].d; rd_en = tbl[i].rd; flush = tbl[i].fl;
      #2;
      chk_all($sformatf("vec%0d", i), tbl[i].ir, tbl[i].ov, tbl[i].od, tbl[i].lvl,
              tbl[i].rts, tbl[i].irq);
    end

    // asynchronous reset while a capture is pending
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h77; rd_en = 1'b0; flush = 1'b0;
    #2 chk("midreset.in_read_before", in_read, 1'b1);
    rstn = 1'b0;
    #1 chk_all("midreset", 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    #1 rstn = 1'b1;

    m_prev = 1'b0; m_rts = 1'b0; m_irq = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      rd_en    = ($urandom_range(0, 2) == 0);
      flush    = ($urandom_range(0, 40) == 0);
      #2;
      e_ir = in_valid && (mq.size() < 4) && !m_prev && !flush;
      e_od = (mq.size() != 0) ? mq[0] : 8'h00;
      chk_all("rand", e_ir, mq.size() != 0, e_od, 3'(mq.size()), m_rts, m_irq);
      if (flush) begin
        mq.delete();
      end else begin
        if (rd_en && mq.size() != 0) void'(mq.pop_front());
        if (e_ir) mq.push_back(in_data);
      end
      m_prev = e_ir;
      m_rts  = (mq.size() >= 3);
      m_irq  = (mq.size() != 0);
    end

`ifdef UART_RX_FIFO_TIMEOUT_IRQ_EN
    @(negedge clk);
    in_valid = 1'b0; rd_en = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk); #2;
    chk("tmo.irq_idle_empty", irq, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h5A;
    #2 chk("tmo.push", in_read, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk); #2;
      chk($sformatf("tmo.irq_after_%0d", n), irq, (n == 17));
    end
    @(negedge clk);
    rd_en = 1'b1;
    #2 chk("tmo.irq_held", irq, 1'b1);
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk); #2;
    chk("tmo.irq_cleared", irq, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
